// File: rtl/mips_alu_pkg.sv
// Shared types and constants for the registered MIPS ALU.
// Optional overflow flag is controlled by the ALU_OVF_EN macro.
package alu_pkg;

   localparam int ALU_W = 32;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_OR  = 2'b10,
      ALU_LUI = 2'b11
   } alu_op_e;

endpackage

// File: rtl/mips_alu_if.sv
// Operand/result bundle between the datapath and mips_alu.
// The ovf signal exists only when ALU_OVF_EN is defined.
interface mips_alu_if;
   import alu_pkg::*;

   logic             in_valid;
   logic [ALU_W-1:0] srcA;
   logic [ALU_W-1:0] srcB;
   alu_op_e          aluOp;
   logic             out_valid;
   logic [ALU_W-1:0] aluResult;
   logic             zero;
`ifdef ALU_OVF_EN
   logic             ovf;

   modport master (output in_valid, srcA, srcB, aluOp,
                   input  out_valid, aluResult, zero, ovf);
   modport slave  (input  in_valid, srcA, srcB, aluOp,
                   output out_valid, aluResult, zero, ovf);
`else
   modport master (output in_valid, srcA, srcB, aluOp,
                   input  out_valid, aluResult, zero);
   modport slave  (input  in_valid, srcA, srcB, aluOp,
                   output out_valid, aluResult, zero);
`endif

endinterface

// File: rtl/mips_alu_comb.sv
// Combinational core: result, zero and (with ALU_OVF_EN) signed overflow
// next-values for the registered ALU stage.
module alu_comb
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] srcA,
   input  logic [ALU_W-1:0] srcB,
   input  alu_op_e          aluOp,
   output logic [ALU_W-1:0] result,
`ifdef ALU_OVF_EN
   output logic             ovf,
`endif
   output logic             zero
);

   logic [ALU_W-1:0] b_eff_s;
   logic             cin_s;
   logic [ALU_W-1:0] sum_s;

   // One adder serves both ADD and SUB; SUB is srcA + ~srcB + 1.
   always_comb begin
      b_eff_s = srcB;
      cin_s   = 1'b0;
      if (aluOp == ALU_SUB) begin
         b_eff_s = ~srcB;
         cin_s   = 1'b1;
      end else begin
         b_eff_s = srcB;
         cin_s   = 1'b0;
      end
      sum_s = srcA + b_eff_s + {{(ALU_W-1){1'b0}}, cin_s};
   end

   // Operation select.
   always_comb begin
      result = {ALU_W{1'b0}};
      case (aluOp)
         ALU_ADD: result = sum_s;
         ALU_SUB: result = sum_s;
         ALU_OR:  result = srcA | srcB;
         ALU_LUI: result = {srcB[15:0], 16'h0000};
         default: result = {ALU_W{1'b0}};
      endcase
      zero = (result == {ALU_W{1'b0}});
   end

`ifdef ALU_OVF_EN
   // Overflow when the effective operands agree in sign but the sum does not.
   always_comb begin
      ovf = 1'b0;
      case (aluOp)
         ALU_ADD: ovf = (srcA[ALU_W-1] == srcB[ALU_W-1]) && (sum_s[ALU_W-1] != srcA[ALU_W-1]);
         ALU_SUB: ovf = (srcA[ALU_W-1] != srcB[ALU_W-1]) && (sum_s[ALU_W-1] != srcA[ALU_W-1]);
         ALU_OR:  ovf = 1'b0;
         ALU_LUI: ovf = 1'b0;
         default: ovf = 1'b0;
      endcase
   end
`endif

endmodule

// File: rtl/mips_alu.sv
// Registered 32-bit ALU: one-cycle latency, outputs hold when idle.
// Define ALU_OVF_EN to add the registered signed-overflow flag.
module mips_alu
   import alu_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   mips_alu_if.slave bus
);

   logic [ALU_W-1:0] result_s;
   logic             zero_s;
   logic [ALU_W-1:0] alu_result_d, alu_result_q;
   logic             zero_d, zero_q;
   logic             out_valid_d, out_valid_q;
`ifdef ALU_OVF_EN
   logic             ovf_s;
   logic             ovf_d, ovf_q;
`endif

   alu_comb u_comb (
      .srcA   (bus.srcA),
      .srcB   (bus.srcB),
      .aluOp  (bus.aluOp),
      .result (result_s),
`ifdef ALU_OVF_EN
      .ovf    (ovf_s),
`endif
      .zero   (zero_s)
   );

   // Load on in_valid, otherwise hold; out_valid simply follows in_valid.
   always_comb begin
      alu_result_d = alu_result_q;
      zero_d       = zero_q;
      out_valid_d  = bus.in_valid;
`ifdef ALU_OVF_EN
      ovf_d        = ovf_q;
`endif
      if (bus.in_valid) begin
         alu_result_d = result_s;
         zero_d       = zero_s;
`ifdef ALU_OVF_EN
         ovf_d        = ovf_s;
`endif
      end else begin
         alu_result_d = alu_result_q;
         zero_d       = zero_q;
`ifdef ALU_OVF_EN
         ovf_d        = ovf_q;
`endif
      end
   end

   // Output register stage; reset wins over a same-cycle operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_result_q <= {ALU_W{1'b0}};
         zero_q       <= 1'b1;
         out_valid_q  <= 1'b0;
`ifdef ALU_OVF_EN
         ovf_q        <= 1'b0;
`endif
      end else begin
         alu_result_q <= alu_result_d;
         zero_q       <= zero_d;
         out_valid_q  <= out_valid_d;
`ifdef ALU_OVF_EN
         ovf_q        <= ovf_d;
`endif
      end
   end

   assign bus.aluResult = alu_result_q;
   assign bus.zero      = zero_q;
   assign bus.out_valid = out_valid_q;
`ifdef ALU_OVF_EN
   assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed plan cases plus random traffic
// against an arithmetic reference model (ovf checked when ALU_OVF_EN is set).
module tb_mips_alu;
   import alu_pkg::*;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   logic [31:0] exp_res;
   logic        exp_zero;
   logic        exp_valid;
   logic        exp_ovf;

   mips_alu_if bus ();

   mips_alu u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic; overflow means the true signed
   // result falls outside the 32-bit signed range.
   function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                          input alu_op_e op);
      longint sa, sb, t;
      logic [31:0] r;
      logic        v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      t  = 64'sd0;
      r  = 32'h0;
      v  = 1'b0;
      case (op)
         ALU_ADD: begin r = a + b; t = sa + sb; v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
         ALU_SUB: begin r = a - b; t = sa - sb; v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
         ALU_OR:  r = a | b;
         default: r = b << 16;
      endcase
      return {v, r};
   endfunction

   // Drive one cycle of inputs, clock it, update the model, compare outputs.
   task automatic step(input logic rst, input logic vld, input logic [31:0] a,
                       input logic [31:0] b, input alu_op_e op, input string tag);
      logic [32:0] m;
      reset        = rst;
      bus.in_valid = vld;
      bus.srcA     = a;
      bus.srcB     = b;
      bus.aluOp    = op;
      @(posedge clk);
      @(negedge clk);
      m = ref_op(a, b, op);
      if (rst) begin
         exp_res = 32'h0; exp_zero = 1'b1; exp_valid = 1'b0; exp_ovf = 1'b0;
      end else if (vld) begin
         exp_res = m[31:0]; exp_zero = (m[31:0] == 32'h0); exp_valid = 1'b1; exp_ovf = m[32];
      end else begin
         exp_valid = 1'b0;
      end
      check_val({tag, ".valid"}, {31'h0, bus.out_valid}, {31'h0, exp_valid});
      check_val({tag, ".result"}, bus.aluResult, exp_res);
      check_val({tag, ".zero"}, {31'h0, bus.zero}, {31'h0, exp_zero});
`ifdef ALU_OVF_EN
      check_val({tag, ".ovf"}, {31'h0, bus.ovf}, {31'h0, exp_ovf});
`endif
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h7FFFFFFF;
         1:       return 32'h80000000;
         2:       return 32'hFFFFFFFF;
         3:       return 32'($urandom_range(0, 3));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      n_checks = 0;
      n_errors = 0;
      exp_res = 32'h0; exp_zero = 1'b1; exp_valid = 1'b0; exp_ovf = 1'b0;
      reset = 1'b1;
      bus.in_valid = 1'b1; bus.srcA = 32'h1; bus.srcB = 32'h1; bus.aluOp = ALU_ADD;
      @(negedge clk);

      step(1'b1, 1'b1, 32'd7, 32'd9, ALU_ADD, "rst0");
      step(1'b1, 1'b1, 32'd7, 32'd9, ALU_OR, "rst1");
      // Fixed expectations from the test plan, independent of the model.
      step(1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, ALU_ADD, "add_wrap");
      check_val("add_wrap.fixed", bus.aluResult, 32'h0);
      step(1'b0, 1'b1, 32'h7FFFFFFF, 32'd1, ALU_ADD, "add_ovf");
      check_val("add_ovf.fixed", bus.aluResult, 32'h80000000);
      step(1'b0, 1'b1, 32'd5, 32'd5, ALU_SUB, "sub_eq");
      check_val("sub_eq.zero_fixed", {31'h0, bus.zero}, 32'h1);
      step(1'b0, 1'b1, 32'd3, 32'd5, ALU_SUB, "sub_neg");
      check_val("sub_neg.fixed", bus.aluResult, 32'hFFFFFFFE);
      step(1'b0, 1'b1, 32'h80000000, 32'd1, ALU_SUB, "sub_ovf");
      step(1'b0, 1'b1, 32'h0000F0F0, 32'h00000F0F, ALU_OR, "or");
      check_val("or.fixed", bus.aluResult, 32'h0000FFFF);
      step(1'b0, 1'b1, 32'hDEADBEEF, 32'h00001234, ALU_LUI, "lui");
      check_val("lui.fixed", bus.aluResult, 32'h12340000);
      step(1'b0, 1'b1, 32'd1, 32'd2, ALU_ADD, "pipe_add");
      check_val("pipe_add.fixed", bus.aluResult, 32'd3);
      step(1'b0, 1'b1, 32'd10, 32'd4, ALU_SUB, "pipe_sub");
      check_val("pipe_sub.fixed", bus.aluResult, 32'd6);
      step(1'b0, 1'b0, 32'd99, 32'd99, ALU_OR, "hold0");
      step(1'b0, 1'b0, 32'd0, 32'd0, ALU_ADD, "hold1");
      check_val("hold.fixed", bus.aluResult, 32'd6);
      step(1'b1, 1'b1, 32'd7, 32'd8, ALU_ADD, "rst_collide");
      check_val("rst_collide.fixed", bus.aluResult, 32'h0);
      step(1'b0, 1'b1, 32'd7, 32'd8, ALU_ADD, "post_rst");

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
              pick_operand(), pick_operand(), alu_op_e'($urandom_range(0, 3)), "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
